// File: rtl/gate_response_checker.sv
// gate_response_checker: observing end of a 2-input gate stimulus/response link.
// It compares the observed gate output against the function selected by GATE_OP
// (0=AND, 1=OR, 2=XOR, 3=NAND). It also keeps saturating sample/error counts and
// input-combination coverage, and captures the first failing {a,b,c}.
// A session ends in DONE once all four {a,b} combinations have been seen.
// Optional macro CHECK_TIMEOUT_EN adds an idle timeout that ends a RUN session
// after TIMEOUT consecutive cycles with no sample.
module gate_response_checker #(
    parameter int unsigned GATE_OP = 0,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             smp_valid,
    input  logic             smp_a,
    input  logic             smp_b,
    input  logic             smp_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic             ff_vld,
    output logic [2:0]       ff_vec,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             exp_c;
    logic             accept;
    logic             mismatch;
    logic [3:0]       cov_nxt;
    logic             cov_full;
    logic [CNT_W-1:0] smp_nxt;
    logic [CNT_W-1:0] err_nxt;
    logic             to_hit;

    // Expected gate output for the current sample
    always_comb begin
        exp_c = smp_a & smp_b;
        case (GATE_OP)
            0:       exp_c = smp_a & smp_b;
            1:       exp_c = smp_a | smp_b;
            2:       exp_c = smp_a ^ smp_b;
            3:       exp_c = ~(smp_a & smp_b);
            default: exp_c = smp_a & smp_b;
        endcase
    end

    // Sample acceptance plus the post-sample counter and coverage values
    always_comb begin
        accept   = (state == RUN) && smp_valid && !start;
        mismatch = (smp_c != exp_c);
        cov_nxt  = cov | (4'b0001 << {smp_a, smp_b});
        cov_full = (cov_nxt == 4'hF);
        smp_nxt  = (smp_cnt == '1) ? smp_cnt : smp_cnt + CNT_W'(1);
        err_nxt  = err_cnt;
        if (mismatch && (err_cnt != '1)) begin
            err_nxt = err_cnt + CNT_W'(1);
        end
    end

`ifdef CHECK_TIMEOUT_EN
    localparam int unsigned IDLE_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_cnt;

    // A sample arriving on the would-be timeout cycle is accepted instead
    assign to_hit = (state == RUN) && !start && !smp_valid && (idle_cnt == IDLE_LAST);

    // Idle cycle counter and timeout flag for the running session
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (start) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (accept) begin
            idle_cnt <= '0;
        end else if (to_hit) begin
            timeout  <= 1'b1;
        end else if (state == RUN) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start restarts from any state and wins over a sample
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if ((accept && cov_full) || to_hit) begin
                        state_nxt = DONE;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Session statistics, coverage, first-fail capture and pass verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt <= '0;
            err_cnt <= '0;
            cov     <= '0;
            ff_vld  <= 1'b0;
            ff_vec  <= '0;
            pass    <= 1'b0;
        end else if (start) begin
            smp_cnt <= '0;
            err_cnt <= '0;
            cov     <= '0;
            ff_vld  <= 1'b0;
            ff_vec  <= '0;
            pass    <= 1'b0;
        end else if (accept) begin
            smp_cnt <= smp_nxt;
            err_cnt <= err_nxt;
            cov     <= cov_nxt;
            if (mismatch && !ff_vld) begin
                ff_vld <= 1'b1;
                ff_vec <= {smp_a, smp_b, smp_c};
            end
            // The coverage-completing sample is included in the verdict
            if (cov_full) begin
                pass <= (err_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: table-driven, hand-written and randomized checks of
// gate_response_checker. Four instances cover GATE_OP 0..3 and a fifth narrow
// counter instance (CNT_W=2) covers saturation; all share one stimulus stream.
module tb_gate_response_checker;

    localparam int NI = 5;
    localparam int TO = 10;

    logic clk;
    logic rst_n;
    logic start;
    logic smp_valid;
    logic smp_a;
    logic smp_b;
    logic smp_c;

    logic       busy_w  [NI];
    logic       done_w  [NI];
    logic       pass_w  [NI];
    logic [7:0] smp_w   [NI];
    logic [7:0] err_w   [NI];
    logic [3:0] cov_w   [NI];
    logic       ffv_w   [NI];
    logic [2:0] ffvec_w [NI];
    logic       to_w    [NI];
    logic [1:0] sat_smp;
    logic [1:0] sat_err;

    for (genvar g = 0; g < 4; g++) begin : g_op
        gate_response_checker #(.GATE_OP(g), .CNT_W(8), .TIMEOUT(TO)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid),
            .smp_a(smp_a), .smp_b(smp_b), .smp_c(smp_c),
            .busy(busy_w[g]), .done(done_w[g]), .pass(pass_w[g]),
            .smp_cnt(smp_w[g]), .err_cnt(err_w[g]), .cov(cov_w[g]),
            .ff_vld(ffv_w[g]), .ff_vec(ffvec_w[g]), .timeout(to_w[g])
        );
    end

    gate_response_checker #(.GATE_OP(0), .CNT_W(2), .TIMEOUT(TO)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid),
        .smp_a(smp_a), .smp_b(smp_b), .smp_c(smp_c),
        .busy(busy_w[4]), .done(done_w[4]), .pass(pass_w[4]),
        .smp_cnt(sat_smp), .err_cnt(sat_err), .cov(cov_w[4]),
        .ff_vld(ffv_w[4]), .ff_vec(ffvec_w[4]), .timeout(to_w[4])
    );
    assign smp_w[4] = {6'd0, sat_smp};
    assign err_w[4] = {6'd0, sat_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state: mode 0=idle, 1=running, 2=finished
    int       m_op    [NI] = '{0, 1, 2, 3, 0};
    int       m_max   [NI] = '{255, 255, 255, 255, 3};
    int       m_mode  [NI];
    int       m_cnt   [NI];
    int       m_err   [NI];
    int       m_idle  [NI];
    bit [3:0] m_cov   [NI];
    bit       m_ffv   [NI];
    bit [2:0] m_ffvec [NI];
    bit       m_pass  [NI];
    bit       m_to    [NI];

    function automatic bit ref_gate(input int op, input bit a, input bit b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return !(a & b);
        endcase
    endfunction

    function automatic int sat_inc(input int v, input int mx);
        return (v + 1 > mx) ? mx : v + 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_mode[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_idle[k] = 0;
            m_cov[k] = '0; m_ffv[k] = 0; m_ffvec[k] = '0; m_pass[k] = 0; m_to[k] = 0;
        end
    endtask

    task automatic model_step(input bit st, input bit v, input bit a, input bit b, input bit c);
        for (int k = 0; k < NI; k++) begin
            if (st) begin
                m_mode[k] = 1; m_cnt[k] = 0; m_err[k] = 0; m_idle[k] = 0;
                m_cov[k] = '0; m_ffv[k] = 0; m_ffvec[k] = '0; m_pass[k] = 0; m_to[k] = 0;
            end else if (m_mode[k] == 1) begin
                if (v) begin
                    m_idle[k] = 0;
                    m_cnt[k] = sat_inc(m_cnt[k], m_max[k]);
                    m_cov[k][{a, b}] = 1'b1;
                    if (c != ref_gate(m_op[k], a, b)) begin
                        m_err[k] = sat_inc(m_err[k], m_max[k]);
                        if (!m_ffv[k]) begin
                            m_ffv[k] = 1;
                            m_ffvec[k] = {a, b, c};
                        end
                    end
                    if (m_cov[k] == 4'hF) begin
                        m_mode[k] = 2;
                        m_pass[k] = (m_err[k] == 0);
                    end
                end
`ifdef CHECK_TIMEOUT_EN
                else begin
                    m_idle[k]++;
                    if (m_idle[k] == TO) begin
                        m_mode[k] = 2; m_to[k] = 1; m_pass[k] = 0;
                    end
                end
`endif
            end
        end
    endtask

    task automatic chk(input string nm, input int k, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s u%0d got %0d expected %0d (t=%0t)", nm, k, got, exp, $time);
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            chk("busy",    k, int'(busy_w[k]),  int'(m_mode[k] == 1));
            chk("done",    k, int'(done_w[k]),  int'(m_mode[k] == 2));
            chk("pass",    k, int'(pass_w[k]),  int'(m_pass[k]));
            chk("smp_cnt", k, int'(smp_w[k]),   m_cnt[k]);
            chk("err_cnt", k, int'(err_w[k]),   m_err[k]);
            chk("cov",     k, int'(cov_w[k]),   int'(m_cov[k]));
            chk("ff_vld",  k, int'(ffv_w[k]),   int'(m_ffv[k]));
            chk("ff_vec",  k, int'(ffvec_w[k]), int'(m_ffvec[k]));
            chk("timeout", k, int'(to_w[k]),    int'(m_to[k]));
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare after it
    task automatic step(input bit st, input bit v, input bit a, input bit b, input bit c);
        start = st; smp_valid = v; smp_a = a; smp_b = b; smp_c = c;
        @(posedge clk);
        model_step(st, v, a, b, c);
        #1;
        start = 1'b0; smp_valid = 1'b0;
        check_all();
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int       gap;
        bit       st, v, a, b, c;
        bit       busy, done, pass;
        int       smp, err;
        bit [3:0] cov;
        bit       ffv;
        bit [2:0] ffvec;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst_n = 1'b0; start = 1'b0; smp_valid = 1'b0;
        smp_a = 1'b0; smp_b = 1'b0; smp_c = 1'b0;
        model_reset();
        #3;
        check_all();
        #5;
        rst_n = 1'b1;

        // AND instance: correct gate, stuck-at-1 gate, DONE behaviour, start/sample collision
        tbl.push_back('{0,  1,0,0,0,0, 1,0,0, 0,0, 4'h0, 0, 3'b000});
        tbl.push_back('{0,  0,1,0,0,0, 1,0,0, 1,0, 4'h1, 0, 3'b000});
        tbl.push_back('{99, 0,1,1,0,0, 1,0,0, 2,0, 4'h5, 0, 3'b000});
        tbl.push_back('{99, 0,1,0,1,0, 1,0,0, 3,0, 4'h7, 0, 3'b000});
        tbl.push_back('{99, 0,1,1,1,1, 0,1,1, 4,0, 4'hF, 0, 3'b000});
        tbl.push_back('{3,  0,1,1,1,0, 0,1,1, 4,0, 4'hF, 0, 3'b000});
        tbl.push_back('{0,  1,0,0,0,0, 1,0,0, 0,0, 4'h0, 0, 3'b000});
        tbl.push_back('{0,  0,1,0,0,1, 1,0,0, 1,1, 4'h1, 1, 3'b001});
        tbl.push_back('{0,  0,1,1,0,1, 1,0,0, 2,2, 4'h5, 1, 3'b001});
        tbl.push_back('{0,  0,1,0,1,1, 1,0,0, 3,3, 4'h7, 1, 3'b001});
        tbl.push_back('{0,  0,1,1,1,1, 0,1,0, 4,3, 4'hF, 1, 3'b001});
        tbl.push_back('{0,  1,1,0,0,0, 1,0,0, 0,0, 4'h0, 0, 3'b000});
        tbl.push_back('{0,  0,1,0,0,0, 1,0,0, 1,0, 4'h1, 0, 3'b000});

        foreach (tbl[i]) begin
            for (int g = 0; g < tbl[i].gap; g++) step(0, 0, 0, 0, 0);
            step(tbl[i].st, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c);
            chk("tbl_busy",   i, int'(busy_w[0]),  int'(tbl[i].busy));
            chk("tbl_done",   i, int'(done_w[0]),  int'(tbl[i].done));
            chk("tbl_pass",   i, int'(pass_w[0]),  int'(tbl[i].pass));
            chk("tbl_smp",    i, int'(smp_w[0]),   tbl[i].smp);
            chk("tbl_err",    i, int'(err_w[0]),   tbl[i].err);
            chk("tbl_cov",    i, int'(cov_w[0]),   int'(tbl[i].cov));
            chk("tbl_ffv",    i, int'(ffv_w[0]),   int'(tbl[i].ffv));
            chk("tbl_ffvec",  i, int'(ffvec_w[0]), int'(tbl[i].ffvec));
        end

        // Mid-session asynchronous reset
        step(0, 1, 1, 0, 0);
        pulse_reset();
        chk("rst_busy", 0, int'(busy_w[0]), 0);
        chk("rst_smp",  0, int'(smp_w[0]),  0);

        // Repeats and saturation on the CNT_W=2 instance
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
        chk("sat_cnt",  4, int'(smp_w[4]), 3);
        chk("sat_cov",  4, int'(cov_w[4]), 1);
        chk("sat_busy", 4, int'(busy_w[4]), 1);
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 0);
        chk("sat_cov3", 4, int'(cov_w[4]), 7);
        chk("sat_nd",   4, int'(done_w[4]), 0);
        step(0, 1, 1, 1, 1);
        chk("sat_done", 4, int'(done_w[4]), 1);
        chk("sat_cntf", 4, int'(smp_w[4]), 3);
        chk("sat_err",  4, int'(err_w[4]), 0);
        chk("sat_covf", 4, int'(cov_w[4]), 15);

        // XOR-correct sequence observed by every gate function
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 1);
        step(0, 1, 1, 0, 1);
        step(0, 1, 1, 1, 0);
        chk("xor_pass",  2, int'(pass_w[2]),  1);
        chk("xor_done",  2, int'(done_w[2]),  1);
        chk("and_err",   0, int'(err_w[0]),   3);
        chk("and_ffvec", 0, int'(ffvec_w[0]), 3);
        chk("and_pass",  0, int'(pass_w[0]),  0);

`ifdef CHECK_TIMEOUT_EN
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 0);
        chk("to_early", 0, int'(done_w[0]), 0);
        step(0, 0, 0, 0, 0);
        chk("to_done", 0, int'(done_w[0]), 1);
        chk("to_flag", 0, int'(to_w[0]),   1);
        chk("to_pass", 0, int'(pass_w[0]), 0);
        chk("to_cov",  0, int'(cov_w[0]),  9);
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
